// File: rtl/phase_cal_ctrl.sv
// phase_cal_ctrl: runtime phase-calibration sequencer for the LO phase shifter.
// Steps the shift word through contiguous coarse sweeps. At each point it
// settles, averages CAL_AVGS ADC samples and compares |avg| against CAL_TOL.
// It stops on lock, or after MAX_SWEEPS sweeps, in which case it writes back
// the best point seen.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, abort       one-cycle control pulses (abort wins)
//   start_shift        first shift value, captured on start
//   adc_data/valid     signed ADC sample and its qualifier
//   adc_req            one-cycle sample request
//   shift_amt/wr       shift word and its write strobe (the word is valid with the strobe)
//   busy, done         run in progress / one-cycle completion pulse
//   locked, fail       result of the last run, held until the next start
//   best_shift/err     best point seen and its unsigned error
//   point_count        points evaluated in the current/last run
module phase_cal_ctrl #(
  parameter int NUM_BITS      = 8,
  parameter int CAL_AVGS      = 1,
  parameter int SWEEP_DIST    = 5,
  parameter int SWEEP_STEP    = 5,
  parameter int CAL_TOL       = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_SWEEPS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_BITS-1:0] start_shift,
  input  logic [NUM_BITS-1:0] adc_data,
  input  logic                adc_valid,
  output logic                adc_req,
  output logic [NUM_BITS-1:0] shift_amt,
  output logic                shift_wr,
  output logic                busy,
  output logic                done,
  output logic                locked,
  output logic                fail,
  output logic [NUM_BITS-1:0] best_shift,
  output logic [NUM_BITS:0]   best_err,
  output logic [15:0]         point_count
);

  localparam int AW = NUM_BITS + 8;
  localparam int EW = NUM_BITS + 1;
  localparam int LOG2_AVGS = $clog2(CAL_AVGS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(SWEEP_DIST + 1);
  localparam int MW = $clog2(MAX_SWEEPS + 1);

  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]       IDX_LAST    = IW'(SWEEP_DIST - 1);
  localparam logic [MW-1:0]       SWEEP_LAST  = MW'(MAX_SWEEPS - 1);
  localparam logic [8:0]          AVG_LAST    = 9'(CAL_AVGS - 1);
  localparam logic [EW-1:0]       TOL         = EW'(CAL_TOL);
  localparam logic [NUM_BITS-1:0] STEP        = NUM_BITS'(SWEEP_STEP);

  typedef enum logic [2:0] {IDLE, SET, SETTLE, REQ, WAIT, EVAL, NEXT, DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_BITS-1:0]   cur, shift_reg, wr_val;
  logic [SW-1:0]         settle_cnt;
  logic [IW-1:0]         idx;
  logic [MW-1:0]         sweep;
  logic [8:0]            nsamp;
  logic signed [AW-1:0]  acc;
  logic signed [NUM_BITS-1:0] avg;
  logic signed [EW-1:0]  avg_x;
  logic [EW-1:0]         err;

  // The average of NUM_BITS-wide samples always fits in NUM_BITS, so the
  // arithmetic shift reduces to a part-select of the accumulator.
  assign avg   = acc[LOG2_AVGS +: NUM_BITS];
  assign avg_x = {avg[NUM_BITS-1], avg};
  assign err   = avg_x[EW-1] ? $unsigned(-avg_x) : $unsigned(avg_x);

  assign busy = (state != IDLE);

  // The strobe carries its value combinationally; shift_reg holds it afterwards.
  assign shift_amt = shift_wr ? wr_val : shift_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_wr  = 1'b0;
    adc_req   = 1'b0;
    done      = 1'b0;
    wr_val    = cur;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (start) state_nxt = SET;
        SET: begin
          shift_wr  = 1'b1;
          state_nxt = SETTLE;
        end
        SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = REQ;
        REQ: begin
          adc_req   = 1'b1;
          state_nxt = WAIT;
        end
        WAIT:   if (adc_valid) state_nxt = (nsamp == AVG_LAST) ? EVAL : REQ;
        EVAL:   state_nxt = (err <= TOL) ? DONE : NEXT;
        NEXT:   state_nxt = (idx == IDX_LAST && sweep == SWEEP_LAST) ? DONE : SET;
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
          if (fail) begin
            shift_wr = 1'b1;
            wr_val   = best_shift;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= '0;
      shift_reg   <= '0;
      settle_cnt  <= '0;
      idx         <= '0;
      sweep       <= '0;
      nsamp       <= '0;
      acc         <= '0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      best_shift  <= '0;
      best_err    <= '1;
      point_count <= '0;
    end else if (abort) begin
      // Partial best/point_count survive; an aborted run reports no result.
      if (state != IDLE) begin
        locked <= 1'b0;
        fail   <= 1'b0;
      end
    end else begin
      if (shift_wr) shift_reg <= wr_val;
      case (state)
        IDLE: if (start) begin
          cur         <= start_shift;
          idx         <= '0;
          sweep       <= '0;
          nsamp       <= '0;
          acc         <= '0;
          point_count <= '0;
          locked      <= 1'b0;
          fail        <= 1'b0;
          best_err    <= '1;
        end
        SET:    settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        WAIT: if (adc_valid) begin
          acc   <= acc + {{8{adc_data[NUM_BITS-1]}}, adc_data};
          nsamp <= nsamp + 9'd1;
        end
        EVAL: begin
          point_count <= point_count + 16'd1;
          if (err < best_err) begin
            best_shift <= cur;
            best_err   <= err;
          end
          if (err <= TOL) locked <= 1'b1;
        end
        NEXT: begin
          acc   <= '0;
          nsamp <= '0;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            sweep <= sweep + MW'(1);
            if (sweep == SWEEP_LAST) fail <= 1'b1;
            else                     cur  <= cur + STEP;
          end else begin
            idx <= idx + IW'(1);
            cur <= cur + STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/phase_cal_ctrl.md
Name: phase_cal_ctrl

Overview:
- Runtime phase-calibration sequencer for the homodyne LO phase shifter (phi_lo_shift_amt / phi_shift_amt path).
- Steps the phase shift word through coarse sweeps and settles after each step. It then requests ADC samples, averages them, and checks the result against a tolerance.
- Stops when the averaged ADC reading is within tolerance, or after a fixed number of sweeps.
- Sits between the config-register block (start/abort, result readback) and the shift-amount register / ADC capture path.

Parameters:
NUM_BITS, 8, width of shift word and signed ADC sample
CAL_AVGS, 1, samples averaged per point; must be a power of two (1..256)
SWEEP_DIST, 5, points per sweep
SWEEP_STEP, 5, shift increment between points, modulo 2^NUM_BITS
CAL_TOL, 10, lock when |avg| <= CAL_TOL
SETTLE_CYCLES, 16, wait cycles after each shift write before sampling (>=1)
MAX_SWEEPS, 8, sweeps before declaring failure

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins calibration (ignored while busy)
abort  in  1  one-cycle pulse; returns to IDLE from any state
start_shift  in  NUM_BITS  first shift value, sampled on start
adc_data  in  NUM_BITS  signed (two's complement) ADC sample
adc_valid  in  1  adc_data valid this cycle
adc_req  out  1  one-cycle sample request pulse
shift_amt  out  NUM_BITS  shift word to phase-shifter register
shift_wr  out  1  one-cycle write strobe for shift_amt
busy  out  1  high from the cycle after start until DONE exits
done  out  1  one-cycle completion pulse
locked  out  1  last run ended within tolerance; held until next start
fail  out  1  last run exhausted MAX_SWEEPS; held until next start
best_shift  out  NUM_BITS  shift value with smallest error seen
best_err  out  NUM_BITS+1  unsigned error at best_shift
point_count  out  16  points evaluated in current/last run

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0, except best_err, which resets to all-ones.
- IDLE: on start, load cur=start_shift. Clear point index, sweep count, accumulator, point_count, locked and fail. Set best_err=all-ones. Go to SET.
- SET (1 cycle): shift_amt<=cur, shift_wr=1. Go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ.
- REQ (1 cycle): adc_req=1. Go to WAIT.
- WAIT: on adc_valid, acc += sign-extended adc_data; acc width is NUM_BITS+8.
  - Fewer than CAL_AVGS samples taken: return to REQ (one request per sample).
  - Otherwise: go to EVAL.
  - No timeout; abort is the only exit.
- EVAL (1 cycle):
  - avg = acc >>> log2(CAL_AVGS) (arithmetic shift).
  - err = |avg| in NUM_BITS+1 bits (-128 gives 128).
  - point_count++.
  - If err < best_err (strict; ties keep the earlier point): best_shift<=cur, best_err<=err.
  - If err <= CAL_TOL: locked<=1, go to DONE.
  - Otherwise go to NEXT.
- NEXT (1 cycle): clear acc; point index++.
  - If index reaches SWEEP_DIST: reset index, sweep++.
  - If sweep reaches MAX_SWEEPS: fail<=1, go to DONE.
  - Otherwise: cur <= cur+SWEEP_STEP (wraps mod 2^NUM_BITS; sweeps continue contiguously), go to SET.
- DONE (1 cycle): done=1.
  - If fail: shift_amt<=best_shift and shift_wr=1 in the same cycle.
  - If locked: shift_amt is already the locked value; no extra write.
  - busy drops the next cycle. Return to IDLE.
- adc_valid outside WAIT is ignored. start while busy is ignored.
- abort has priority over every transition:
  - Go to IDLE next cycle.
  - done, locked and fail stay 0; shift_amt holds its last value.
  - best_shift, best_err and point_count keep their partial results.
  - start and abort in the same cycle: abort wins.
- Reset mid-run: immediate return to reset values. No shift_wr or adc_req glitch.

Test Plan:
- Lock on third point:
  - Stimulus: start_shift=0, defaults. ADC model returns 50, -40, 5 on successive requests.
  - Response: shift_wr pulses with 0, 5, 10; done with locked=1, fail=0; best_shift=10, best_err=5, point_count=3, shift_amt=10.
  - Each adc_req is exactly SETTLE_CYCLES+1 cycles after its shift_wr.
- Failure:
  - Stimulus: ADC always returns -128.
  - Response: 40 points evaluated; done with fail=1; best_err=128, best_shift=start_shift; final shift_wr carries start_shift.
- Averaging:
  - Stimulus: CAL_AVGS=4, samples 20, -4, 8, 0.
  - Response: 4 adc_req pulses; avg=6; locked on first point.
  - Samples 30, 30, 30, 31 give avg=30: not locked, advances.
- Wrap-around:
  - Stimulus: start_shift=253, ADC returns 100, then 3.
  - Response: shift writes 253 then 2; locked, best_shift=2.
- Abort:
  - Stimulus: abort during WAIT of point 2, then stray adc_valid; next start.
  - Response: busy=0, done never pulses, stray sample ignored. Next start runs cleanly from its start_shift with point_count reset.
- Async reset:
  - Stimulus: rst low mid-SETTLE, asynchronous to clk.
  - Response: outputs go to reset values immediately; no adc_req after release until a new start.
